// File: rtl/ledmatrix_pkg.sv
// Shared constants for the LED-matrix serial receiver: register addresses and receiver FSM states.
package ledmatrix_pkg;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } rx_state_t;

endpackage

// File: rtl/ledmatrix_rx_serial.sv
// Generic oversampling serial word receiver: synchronise, detect edges, shift, and strobe the
// word (valid) or a short transfer (error) combinationally during the LATCH cycle.
module serial_rx
  import ledmatrix_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int LOWBIT_FIRST = 0,
  parameter int FALLING_EDGE = 0,
  parameter int SEL_ACTIVE   = 0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ser_clk,
  input  logic            ser_dat,
  input  logic            ser_sel,
  output logic [BITS-1:0] word,
  output logic            valid,
  output logic            error
);

  localparam int   CW  = $clog2(BITS + 1);
  localparam logic ACT = (SEL_ACTIVE != 0);

  // {sel, dat, clk} per stage; the chain is left unreset so a select held active across
  // reset never looks like a fresh edge once reset releases.
  logic [SYNC_STAGES-1:0][2:0] sync;
  logic [2:0]                  cur, prev;

  always_ff @(posedge clk) begin
    sync <= {sync[SYNC_STAGES-2:0], {ser_sel, ser_dat, ser_clk}};
    prev <= cur;
  end

  assign cur = sync[SYNC_STAGES-1];

  logic sel_on, sel_off, samp, dat;
  assign sel_on  = (cur[2] == ACT) && (prev[2] != ACT);
  assign sel_off = (cur[2] != ACT) && (prev[2] == ACT);
  assign samp    = (FALLING_EDGE != 0) ? (prev[0] & ~cur[0]) : (cur[0] & ~prev[0]);
  assign dat     = cur[1];

  rx_state_t       state;
  logic [BITS-1:0] shreg, nxt;
  logic [CW-1:0]   cnt;
  logic            pend;

  assign nxt = (LOWBIT_FIRST != 0) ? {dat, shreg[BITS-1:1]} : {shreg[BITS-2:0], dat};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pend <= 1'b0;
          if (sel_on || pend) begin
            state <= SHIFT;
            shreg <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          // a bit landing in the same cycle as the closing select edge still counts
          if (samp) begin
            shreg <= nxt;
            if (cnt != CW'(BITS)) cnt <= cnt + 1'b1;
          end
          if (sel_off) state <= LATCH;
        end
        LATCH: begin
          state <= IDLE;
          pend  <= sel_on;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign word  = shreg;
  assign valid = (state == LATCH) && (cnt == CW'(BITS));
  assign error = (state == LATCH) && (cnt != CW'(BITS));

endmodule

// File: rtl/ledmatrix_rx.sv
// LED-matrix controller emulation: receives serial words and decodes them into the row
// frame and control registers; all outputs are registered.
module ledmatrix_rx
  import ledmatrix_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int LOWBIT_FIRST = 0,
  parameter int FALLING_EDGE = 0,
  parameter int SEL_ACTIVE   = 0,
  parameter int NUM_SEGS     = 8,
  parameter int LEDS_PER_SEG = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                             in_clk,
  input  logic                             in_rst,
  input  logic                             in_ser_clk,
  input  logic                             in_ser_dat,
  input  logic                             in_ser_sel,
  output logic [BITS-1:0]                  out_word,
  output logic                             out_word_valid,
  output logic [NUM_SEGS*LEDS_PER_SEG-1:0] out_frame,
  output logic                             out_frame_updated,
  output logic [3:0]                       out_intensity,
  output logic [2:0]                       out_scan_limit,
  output logic [7:0]                       out_decode,
  output logic                             out_shutdown,
  output logic                             out_test,
  output logic                             out_error
);

  logic [BITS-1:0] rx_word;
  logic            rx_valid, rx_error;

  serial_rx #(
    .BITS         (BITS),
    .LOWBIT_FIRST (LOWBIT_FIRST),
    .FALLING_EDGE (FALLING_EDGE),
    .SEL_ACTIVE   (SEL_ACTIVE),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_rx (
    .clk     (in_clk),
    .rst     (in_rst),
    .ser_clk (in_ser_clk),
    .ser_dat (in_ser_dat),
    .ser_sel (in_ser_sel),
    .word    (rx_word),
    .valid   (rx_valid),
    .error   (rx_error)
  );

  logic [3:0] addr;
  logic [7:0] data;
  logic       unused_hi;

  assign addr      = rx_word[11:8];
  assign data      = rx_word[7:0];
  assign unused_hi = ^rx_word[BITS-1:12];

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      out_word          <= '0;
      out_word_valid    <= 1'b0;
      out_frame         <= '0;
      out_frame_updated <= 1'b0;
      out_intensity     <= '0;
      out_scan_limit    <= '0;
      out_decode        <= '0;
      out_shutdown      <= 1'b1;
      out_test          <= 1'b0;
      out_error         <= 1'b0;
    end else begin
      out_word_valid    <= 1'b0;
      out_frame_updated <= 1'b0;
      out_error         <= rx_error;
      if (rx_valid) begin
        out_word       <= rx_word;
        out_word_valid <= 1'b1;
        for (int r = 0; r < NUM_SEGS; r++) begin
          if (addr == 4'(r + 1)) begin
            out_frame[r*LEDS_PER_SEG +: LEDS_PER_SEG] <= data[LEDS_PER_SEG-1:0];
            out_frame_updated <= 1'b1;
          end
        end
        case (addr)
          ADDR_DECODE:    out_decode     <= data;
          ADDR_INTENSITY: out_intensity  <= data[3:0];
          ADDR_SCANLIM:   out_scan_limit <= data[2:0];
          ADDR_SHUTDOWN:  out_shutdown   <= ~data[0];
          ADDR_TEST:      out_test       <= data[0];
          default: ;
        endcase
      end
    end
  end

endmodule
